// File: rtl/audio_menu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_menu_ctrl: three-button audio mode menu with 2-digit 7-seg display.  |
// | Optional macro MENU_WRAP_EN: wrap candidate index at the range ends.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module audio_menu_ctrl #(
  parameter int NUM_MODES      = 7,
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLINK_CYCLES   = 256,
  parameter int REFRESH_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up,
  input  logic                 down,
  input  logic                 ok,
  output logic [NUM_MODES-1:0] mode_en,
  output logic [2:0]           mode_idx,
  output logic                 browsing,
  output logic [6:0]           seg,
  output logic [1:0]           an
);

  localparam int c_deb_w = $clog2(DEB_CYCLES + 1);
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_blk_w = $clog2(BLINK_CYCLES + 1);
  localparam int c_ref_w = $clog2(REFRESH_CYCLES + 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  assign btn_raw = {ok, down, up};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic               sync1_q, sync2_q, deb_q, deb_d, prev_q, pulse_q;
    logic [c_deb_w-1:0] cnt_q, cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == c_deb_w'(DEB_CYCLES - 1)) deb_d = sync2_q;
        else cnt_d = cnt_q + c_deb_w'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        prev_q  <= deb_q;
        pulse_q <= deb_q & ~prev_q;
      end
    end

    assign btn_pulse[i] = pulse_q;
  end

  typedef enum logic [0:0] {IDLE = 1'b0, BROWSE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cand_q, cand_d, idx_q, idx_d, disp_idx;
  logic [NUM_MODES-1:0] mode_en_q, mode_en_d;
  logic [c_tmo_w-1:0]   tmo_q, tmo_d;
  logic [c_blk_w-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_off_q, blink_off_d;
  logic [c_ref_w-1:0]   ref_cnt_q, ref_cnt_d;
  logic                 dig_sel_q, dig_sel_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;
  logic                 up_p, dn_p, ok_p, step_p;

  function automatic logic [2:0] step_up(input logic [2:0] v);
    if (v == 3'(NUM_MODES - 1)) begin
`ifdef MENU_WRAP_EN
      return 3'd0;
`else
      return v;
`endif
    end
    return v + 3'd1;
  endfunction

  function automatic logic [2:0] step_dn(input logic [2:0] v);
    if (v == 3'd0) begin
`ifdef MENU_WRAP_EN
      return 3'(NUM_MODES - 1);
`else
      return v;
`endif
    end
    return v - 3'd1;
  endfunction

  function automatic logic [6:0] glyph(input logic [2:0] v);
    case (v)
      3'd0:    return 7'b1111110;
      3'd1:    return 7'b0110001;
      3'd2:    return 7'b1001111;
      3'd3:    return 7'b0110000;
      3'd4:    return 7'b1110001;
      3'd5:    return 7'b1001000;
      3'd6:    return 7'b0011000;
      default: return 7'b1000001;
    endcase
  endfunction

  function automatic logic [6:0] numeral(input logic [2:0] v);
    case (v)
      3'd0:    return 7'b0000001;
      3'd1:    return 7'b1001111;
      3'd2:    return 7'b0010010;
      3'd3:    return 7'b0000110;
      3'd4:    return 7'b1001100;
      3'd5:    return 7'b0100100;
      3'd6:    return 7'b0100000;
      default: return 7'b0001111;
    endcase
  endfunction

  always_comb begin
    up_p        = btn_pulse[0];
    dn_p        = btn_pulse[1];
    ok_p        = btn_pulse[2];
    step_p      = up_p ^ dn_p;
    state_d     = state_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    blink_cnt_d = '0;
    blink_off_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (step_p) begin
          state_d = BROWSE;
          cand_d  = up_p ? step_up(idx_q) : step_dn(idx_q);
          tmo_d   = '0;
        end
      end
      default: begin
        if (blink_cnt_q == c_blk_w'(BLINK_CYCLES - 1)) begin
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + c_blk_w'(1);
          blink_off_d = blink_off_q;
        end
        // ok wins over a same-cycle step, so the pre-step candidate commits
        if (ok_p) begin
          idx_d   = cand_q;
          state_d = IDLE;
          tmo_d   = '0;
        end else if (step_p) begin
          cand_d = up_p ? step_up(cand_q) : step_dn(cand_q);
          tmo_d  = '0;
        end else if (tmo_q == c_tmo_w'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          cand_d  = idx_q;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + c_tmo_w'(1);
        end
      end
    endcase

    for (int i = 0; i < NUM_MODES; i++) mode_en_d[i] = (idx_d == 3'(i));

    if (ref_cnt_q == c_ref_w'(REFRESH_CYCLES - 1)) begin
      ref_cnt_d = '0;
      dig_sel_d = ~dig_sel_q;
    end else begin
      ref_cnt_d = ref_cnt_q + c_ref_w'(1);
      dig_sel_d = dig_sel_q;
    end

    disp_idx = (state_q == BROWSE) ? cand_q : idx_q;
    an_d     = dig_sel_q ? 2'b01 : 2'b10;
    seg_d    = dig_sel_q ? numeral(disp_idx) : glyph(disp_idx);
    if (state_q == BROWSE && blink_off_q) seg_d = 7'b1111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= 3'd0;
      idx_q       <= 3'd0;
      mode_en_q   <= NUM_MODES'(1);
      tmo_q       <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      ref_cnt_q   <= '0;
      dig_sel_q   <= 1'b0;
      seg_q       <= 7'b1111111;
      an_q        <= 2'b10;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      idx_q       <= idx_d;
      mode_en_q   <= mode_en_d;
      tmo_q       <= tmo_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      ref_cnt_q   <= ref_cnt_d;
      dig_sel_q   <= dig_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign mode_en  = mode_en_q;
  assign mode_idx = idx_q;
  assign browsing = (state_q == BROWSE);
  assign seg      = seg_q;
  assign an       = an_q;

endmodule
`default_nettype wire

// File: doc/audio_menu_ctrl.md
AUDIO_MENU_CTRL -- requirements
Module: audio_menu_ctrl

Interface
REQ-001 Parameter NUM_MODES, default 7, range 2..8: number of selectable audio modes; index 0 is bypass.
REQ-002 Parameter DEB_CYCLES, default 16: debounce stability count.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: idle cycles before browse is abandoned.
REQ-004 Parameter BLINK_CYCLES, default 256: half-period of the browse blink.
REQ-005 Parameter REFRESH_CYCLES, default 64: dwell per digit in display multiplexing.
REQ-006 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Ports up, down, ok, input, 1 each: raw asynchronous push-buttons, active-high.
REQ-009 Port mode_en, output, NUM_MODES: one-hot committed mode; bit0 is bypass.
REQ-010 Port mode_idx, output, 3: binary committed mode index.
REQ-011 Port browsing, output, 1: high while in BROWSE.
REQ-012 Port seg, output, 7: active-low segments; bit6 = a ... bit0 = g.
REQ-013 Port an, output, 2: active-low digit enables; an[0] = glyph digit, an[1] = index digit.

Function
REQ-014 Each button SHALL pass a 2-FF synchroniser, then a debouncer that updates its state after DEB_CYCLES consecutive cycles of disagreement; any agreement clears the count.
REQ-015 A one-cycle press pulse SHALL fire on each debounced rising edge, DEB_CYCLES+3 cycles after a clean raw rise; releases generate nothing.
REQ-016 FSM states SHALL be IDLE and BROWSE; candidate index cand SHALL load from the committed index on IDLE->BROWSE.
REQ-017 IDLE: an up or down pulse SHALL enter BROWSE with cand stepped +1 or -1 from committed; ok SHALL be ignored.
REQ-018 BROWSE: an up or down pulse SHALL step cand and restart the timeout counter.
REQ-019 BROWSE: an ok pulse SHALL commit cand and return to IDLE; mode_en and mode_idx SHALL update on the cycle after the pulse.
REQ-020 BROWSE: TIMEOUT_CYCLES cycles without a pulse SHALL return to IDLE with cand discarded and the committed mode unchanged.
REQ-021 Simultaneous up and down pulses SHALL be ignored entirely, with no step and no timeout restart.
REQ-022 ok together with up or down SHALL commit the pre-step cand; the step SHALL be dropped.
REQ-023 cand stepping boundaries (NUM_MODES-1 going up, 0 going down) SHALL follow REQ-032.
REQ-024 Multiplexing: an SHALL alternate 2'b10 and 2'b01, each held REFRESH_CYCLES cycles.
REQ-025 Glyph digit SHALL show the displayed index (cand in BROWSE, committed in IDLE).
  - 0 '-' 1111110
  - 1 'C' 0110001
  - 2 'I' 1001111
  - 3 'E' 0110000
  - 4 'L' 1110001
  - 5 'H' 1001000
  - 6 'P' 0011000
  - 7 'U' 1000001
REQ-026 Index digit SHALL show the same index as a numeral.
  - 0 0000001
  - 1 1001111
  - 2 0010010
  - 3 0000110
  - 4 1001100
  - 5 0100100
  - 6 0100000
  - 7 0001111
REQ-027 BROWSE: seg SHALL be forced to 1111111 during the off phase of a blink toggling every BLINK_CYCLES; the phase SHALL start visible on each BROWSE entry.
REQ-028 IDLE: the display SHALL be steady.
REQ-029 seg and an SHALL be registered, one cycle behind the mux select.

Reset
REQ-030 While rst is high, the block SHALL hold:
  - state IDLE; committed and cand 0
  - mode_en = 1, mode_idx = 0, browsing = 0
  - seg = 1111111, an = 2'b10
  - debouncers, counters and blink phase cleared
REQ-031 Reset asserted mid-BROWSE SHALL discard cand immediately; pulses in flight SHALL be lost.

Configuration
REQ-032 Macro MENU_WRAP_EN controls stepping at the ends of the range.
  - Defined: up at NUM_MODES-1 SHALL wrap to 0; down at 0 SHALL wrap to NUM_MODES-1.
  - Undefined: cand SHALL saturate at 0 and NUM_MODES-1; the pulse still restarts the timeout.

Verification (DEB_CYCLES=4, TIMEOUT_CYCLES=64, BLINK_CYCLES=8, REFRESH_CYCLES=4)
REQ-033 Release rst, no buttons -> mode_en=0000001, mode_idx=0, browsing=0; an alternates every 4 cycles; seg shows 1111110 and 0000001.
REQ-034 Raw up held 20 cycles from IDLE mode 0 -> browsing=1 at raw+8; glyph 'C'; ok press -> mode_en=0000010 at raw_ok+8.
REQ-035 up glitch of 3 cycles -> no pulse, browsing stays 0.
REQ-036 Enter BROWSE, no further input -> browsing=0 exactly 64 cycles after the last pulse; mode_idx unchanged; seg blanks 8 of every 16 cycles meanwhile.
REQ-037 Committed 6, press up then ok -> with MENU_WRAP_EN mode_idx=0; without it mode_idx=6.
REQ-038 up and down pulses in the same cycle during BROWSE -> cand unchanged; timeout still expires 64 cycles after the previous pulse.
